cpu_commit_stage: RTL and testbench

- Memory/commit stage directly downstream of execute; consumes registered commit control, ALU result and store data.
- Performs loads/stores against the data cache through a req/ready handshake, with a STORE_BUF_DEPTH store buffer that retires stores without stalling.
- Produces the registered writeback bundle for the register bank, plus the combinational commit-stage forwarding and stall signals.

---
 rtl/cpu_commit_stage.sv | 176 +++++++++++++++++
 tb/tb_cpu_commit_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_commit_stage.sv
// rtl/cpu_commit_stage.sv - commit stage: cache loads/stores through a store buffer, registered writeback
module cpu_commit_stage #(
  parameter int REG_WIDTH       = 32,
  parameter int NUM_REGS        = 32,
  parameter int STORE_BUF_DEPTH = 4,
  localparam int RID_W = $clog2(NUM_REGS),
  localparam int PW    = $clog2(STORE_BUF_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [REG_WIDTH-1:0] in_alu_result,
  input  logic [REG_WIDTH-1:0] in_rb_data,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic                 in_byte,
  input  logic                 in_writeback,
  input  logic [RID_W-1:0]     in_reg_dest,
  output logic                 stall_out,
  output logic                 dc_req,
  output logic                 dc_we,
  output logic [REG_WIDTH-1:0] dc_addr,
  output logic [REG_WIDTH-1:0] dc_wdata,
  output logic                 dc_byte,
  input  logic                 dc_ready,
  input  logic [REG_WIDTH-1:0] dc_rdata,
  output logic                 fwd_valid,
  output logic [RID_W-1:0]     fwd_rd_id,
  output logic [REG_WIDTH-1:0] fwd_value,
  output logic                 wb_valid,
  output logic [RID_W-1:0]     wb_rd_id,
  output logic [REG_WIDTH-1:0] wb_value
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PW:0]          count_q, count_d;
  logic                 hold_q, hold_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [RID_W-1:0]     wb_rd_id_q, wb_rd_id_d;
  logic [REG_WIDTH-1:0] wb_value_q, wb_value_d;
  logic [REG_WIDTH-1:0] buf_addr_q [STORE_BUF_DEPTH];
  logic [REG_WIDTH-1:0] buf_addr_d [STORE_BUF_DEPTH];
  logic [REG_WIDTH-1:0] buf_data_q [STORE_BUF_DEPTH];
  logic [REG_WIDTH-1:0] buf_data_d [STORE_BUF_DEPTH];
  logic                 buf_byte_q [STORE_BUF_DEPTH];
  logic                 buf_byte_d [STORE_BUF_DEPTH];

  logic                 is_load, is_store, hit_any, hit_byte, load_miss;
  logic                 store_port, load_port, pop, push, full, complete;
  logic [PW-1:0]        idx;
  logic [REG_WIDTH-1:0] hit_data, load_value;

  function automatic logic [REG_WIDTH-1:0] extract(input logic [REG_WIDTH-1:0] w,
                                                   input logic [1:0] sel, input logic is_byte);
    logic [REG_WIDTH-1:0] sh;
    sh = w >> {sel, 3'b000};
    return is_byte ? {{(REG_WIDTH-8){1'b0}}, sh[7:0]} : w;
  endfunction

  always_comb begin
    // Scan oldest to youngest so the last match wins.
    hit_any  = 1'b0;
    hit_byte = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < STORE_BUF_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((PW+1)'(k) < count_q && buf_addr_q[idx][REG_WIDTH-1:2] == in_alu_result[REG_WIDTH-1:2]) begin
        hit_any  = 1'b1;
        hit_byte = buf_byte_q[idx];
        hit_data = buf_data_q[idx];
      end
    end

    is_load   = in_valid & in_mem_read;
    is_store  = in_valid & in_mem_write & ~in_mem_read;
    load_miss = (state_q == IDLE) & is_load & ~hit_any;
    full      = (count_q == (PW+1)'(STORE_BUF_DEPTH));

    // A presented store (hold_q) keeps the port even if a load shows up.
    store_port = (count_q != '0) & (hold_q | (state_q == DRAIN) | ((state_q == IDLE) & ~load_miss));
    load_port  = (state_q == LOAD_WAIT) & ~hold_q;
    pop        = store_port & dc_ready;

    complete   = 1'b0;
    load_value = extract(hit_data, in_alu_result[1:0], in_byte);
    case (state_q)
      IDLE: begin
        if (is_load)       complete = hit_any & ~hit_byte;
        else if (is_store) complete = ~full | pop;
        else               complete = in_valid;
      end
      LOAD_WAIT: begin
        complete   = in_valid & load_port & dc_ready;
        load_value = extract(dc_rdata, in_alu_result[1:0], in_byte);
      end
      default: complete = 1'b0;
    endcase
    push = (state_q == IDLE) & is_store & complete;

    state_d = state_q;
    case (state_q)
      IDLE:      if (is_load & ~(hit_any & ~hit_byte)) state_d = hit_any ? DRAIN : LOAD_WAIT;
      LOAD_WAIT: if (load_port & dc_ready) state_d = IDLE;
      DRAIN:     if (count_q == '0) state_d = LOAD_WAIT;
      default:   state_d = IDLE;
    endcase

    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_byte_d = buf_byte_q;
    if (push) begin
      buf_addr_d[tail_q] = in_alu_result;
      buf_data_d[tail_q] = in_rb_data;
      buf_byte_d[tail_q] = in_byte;
    end
    tail_d  = tail_q + PW'(push);
    head_d  = head_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    hold_d  = store_port & ~dc_ready;

    wb_valid_d = 1'b0;
    wb_rd_id_d = wb_rd_id_q;
    wb_value_d = wb_value_q;
    if (complete) begin
      wb_valid_d = in_writeback;
      wb_rd_id_d = in_reg_dest;
      wb_value_d = in_mem_read ? load_value : in_alu_result;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      hold_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_id_q <= '0;
      wb_value_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_id_q <= wb_rd_id_d;
      wb_value_q <= wb_value_d;
    end
  end

  always_ff @(posedge clock) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
    buf_byte_q <= buf_byte_d;
  end

  assign dc_req    = store_port | load_port;
  assign dc_we     = store_port;
  assign dc_addr   = store_port ? buf_addr_q[head_q] : (load_port ? in_alu_result : '0);
  assign dc_wdata  = store_port ? buf_data_q[head_q] : '0;
  assign dc_byte   = store_port ? buf_byte_q[head_q] : (load_port & in_byte);
  assign stall_out = in_valid & ~complete;
  assign fwd_valid = in_valid & in_writeback & ~in_mem_read;
  assign fwd_rd_id = in_reg_dest;
  assign fwd_value = in_alu_result;
  assign wb_valid  = wb_valid_q;
  assign wb_rd_id  = wb_rd_id_q;
  assign wb_value  = wb_value_q;

endmodule

// File: tb/tb_cpu_commit_stage.sv
// tb/tb_cpu_commit_stage.sv - self-checking bench for cpu_commit_stage
module tb_cpu_commit_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write, in_byte, in_writeback;
  logic [31:0] in_alu_result, in_rb_data;
  logic [4:0]  in_reg_dest;
  logic        stall_out, dc_req, dc_we, dc_byte, dc_ready;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic        fwd_valid, wb_valid;
  logic [4:0]  fwd_rd_id, wb_rd_id;
  logic [31:0] fwd_value, wb_value;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q [$];

  cpu_commit_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_rb_data(in_rb_data), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_byte(in_byte), .in_writeback(in_writeback), .in_reg_dest(in_reg_dest),
    .stall_out(stall_out), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_byte(dc_byte), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .fwd_valid(fwd_valid), .fwd_rd_id(fwd_rd_id), .fwd_value(fwd_value),
    .wb_valid(wb_valid), .wb_rd_id(wb_rd_id), .wb_value(wb_value)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Writeback scoreboard: each expected {rd, value} is consumed when wb_valid shows up.
  always @(negedge clock) begin
    if (!reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {27'd0, wb_rd_id}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_rd_id", {27'd0, wb_rd_id}, {27'd0, e[36:32]});
        check("wb_value", wb_value, e[31:0]);
      end
    end
  end

  task automatic drive(input logic v, input logic rd, input logic wr, input logic byt, input logic wbk,
                       input logic [31:0] alu, input logic [31:0] rb, input logic [4:0] dest);
    in_valid = v; in_mem_read = rd; in_mem_write = wr; in_byte = byt;
    in_writeback = wbk; in_alu_result = alu; in_rb_data = rb; in_reg_dest = dest;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic rd, wr, byt, wbk;
    logic [31:0] alu, rb;
    logic [4:0]  dest;
    logic        exp_stall;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs [9];
  int   stalls;
  logic saw_store, saw_load, done;

  initial begin
    vecs[0] = '{0, 0, 0, 1, 32'h15,  32'h0,         5'd3,  0, 32'h15};
    vecs[1] = '{0, 1, 0, 0, 32'h100, 32'hDEADBEEF,  5'd0,  0, 32'h0};
    vecs[2] = '{1, 0, 0, 1, 32'h100, 32'h0,         5'd4,  0, 32'hDEADBEEF};
    vecs[3] = '{1, 0, 1, 1, 32'h103, 32'h0,         5'd5,  0, 32'h000000DE};
    vecs[4] = '{1, 0, 1, 1, 32'h101, 32'h0,         5'd6,  0, 32'h000000BE};
    vecs[5] = '{0, 0, 0, 0, 32'h77,  32'h0,         5'd7,  0, 32'h0};
    vecs[6] = '{0, 1, 0, 0, 32'h108, 32'h11223344,  5'd0,  0, 32'h0};
    vecs[7] = '{1, 0, 1, 1, 32'h10A, 32'h0,         5'd12, 0, 32'h00000022};
    vecs[8] = '{0, 1, 0, 0, 32'h100, 32'hAABBCCDD,  5'd0,  0, 32'h0};

    reset = 1'b1; dc_ready = 1'b0; dc_rdata = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    @(negedge clock);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_value", wb_value, 32'd0);
    check("rst_dc_req", {31'd0, dc_req}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    // Single-cycle rows with the cache never ready; stores stay buffered.
    for (int i = 0; i < 9; i++) begin
      drive(1, vecs[i].rd, vecs[i].wr, vecs[i].byt, vecs[i].wbk, vecs[i].alu, vecs[i].rb, vecs[i].dest);
      @(negedge clock);
      check($sformatf("row%0d_stall", i), {31'd0, stall_out}, {31'd0, vecs[i].exp_stall});
      check($sformatf("row%0d_fwd_valid", i), {31'd0, fwd_valid},
            {31'd0, vecs[i].wbk & ~vecs[i].rd});
      check($sformatf("row%0d_no_load_req", i), {31'd0, dc_req & ~dc_we}, 32'd0);
      if (vecs[i].wbk && !vecs[i].exp_stall) exp_q.push_back({vecs[i].dest, vecs[i].exp_wb});
      step();
    end
    vecs[0] = '{0, 0, 0, 1, 32'hFFFFFFFF, 32'h0, 5'd1, 0, 32'hFFFFFFFF};
    drive(1, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 5'd1);
    @(negedge clock);
    check("fwd_value", fwd_value, 32'hFFFFFFFF);
    check("fwd_rd_id", {27'd0, fwd_rd_id}, 32'd1);
    exp_q.push_back({5'd1, 32'hFFFFFFFF});
    step();

    // Drain the three buffered stores in program order.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    dc_ready = 1'b1;
    @(negedge clock);
    check("drain0_we", {31'd0, dc_req & dc_we}, 32'd1);
    check("drain0_addr", dc_addr, 32'h100);
    check("drain0_data", dc_wdata, 32'hDEADBEEF);
    step(); @(negedge clock);
    check("drain1_addr", dc_addr, 32'h108);
    step(); @(negedge clock);
    check("drain2_addr", dc_addr, 32'h100);
    check("drain2_data", dc_wdata, 32'hAABBCCDD);
    step(); @(negedge clock);
    check("drained_req", {31'd0, dc_req}, 32'd0);
    step();

    // Byte store then overlapping word load: drain first, then a cache load.
    dc_ready = 1'b0;
    drive(1, 0, 1, 1, 0, 32'h101, 32'h00000055, 0);
    @(negedge clock);
    check("bstore_stall", {31'd0, stall_out}, 32'd0);
    step();
    drive(1, 1, 0, 0, 1, 32'h100, 0, 5'd8);
    dc_ready = 1'b1; dc_rdata = 32'hCAFE0055;
    stalls = 0; saw_store = 0; saw_load = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (dc_req && dc_we && dc_addr == 32'h101 && dc_byte && dc_wdata[7:0] == 8'h55) saw_store = 1;
      if (dc_req && !dc_we && dc_addr == 32'h100) saw_load = 1;
      if (stall_out) stalls++;
      else begin
        done = 1;
        exp_q.push_back({5'd8, 32'hCAFE0055});
      end
      step();
    end
    check("drain_done", {31'd0, done}, 32'd1);
    check("drain_saw_store", {31'd0, saw_store}, 32'd1);
    check("drain_saw_load", {31'd0, saw_load}, 32'd1);
    check("drain_stalls", stalls, 2);

    // Cache miss answered on the fourth cycle.
    dc_ready = 1'b0;
    drive(1, 1, 0, 0, 1, 32'h200, 0, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("miss_stall%0d", c), {31'd0, stall_out}, 32'd1);
      step();
    end
    dc_ready = 1'b1; dc_rdata = 32'h12345678;
    @(negedge clock);
    check("miss_done", {31'd0, stall_out}, 32'd0);
    check("miss_req", {30'd0, dc_req, dc_we}, 32'd2);
    check("miss_addr", dc_addr, 32'h200);
    exp_q.push_back({5'd9, 32'h12345678});
    step();
    dc_ready = 1'b0;

    // Five stores against a stalled cache; the fifth enters when the head pops.
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 1, 0, 0, 32'h300 + 32'(4 * k), 32'hA0 + 32'(k), 0);
      @(negedge clock);
      check($sformatf("fill%0d_stall", k), {31'd0, stall_out}, {31'd0, k == 4});
      if (k < 4) step();
    end
    step(); @(negedge clock);
    check("full_hold_stall", {31'd0, stall_out}, 32'd1);
    step();
    dc_ready = 1'b1;
    @(negedge clock);
    check("full_pop_accept", {31'd0, stall_out}, 32'd0);
    check("full_pop_addr", dc_addr, 32'h300);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("wrap_addr%0d", k), dc_addr, 32'h300 + 32'(4 * k));
      check($sformatf("wrap_data%0d", k), dc_wdata, 32'hA0 + 32'(k));
      step();
    end
    @(negedge clock);
    check("wrap_empty", {31'd0, dc_req}, 32'd0);
    step();

    // Reset while a load waits, with a store still buffered.
    dc_ready = 1'b0;
    drive(1, 0, 1, 0, 0, 32'h500, 32'h99, 0);
    step();
    drive(1, 1, 0, 0, 1, 32'h400, 0, 5'd10);
    step(); @(negedge clock);
    check("lw_req", {30'd0, dc_req, dc_we}, 32'd2);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_lw_req", {31'd0, dc_req}, 32'd0);
    check("rst_lw_wb", {31'd0, wb_valid}, 32'd0);
    step();
    drive(1, 0, 0, 0, 1, 32'h42, 0, 5'd11);
    @(negedge clock);
    check("post_rst_stall", {31'd0, stall_out}, 32'd0);
    exp_q.push_back({5'd11, 32'h42});
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
